// File: rtl/synth_pkg.sv
// Shared types and defaults for the synth voice allocator and its voice bank.
package synth_pkg;

    localparam int DEF_NUM_VOICES = 8;
    localparam int DEF_NOTE_W     = 7;
    localparam int DEF_VEL_W      = 3;

    typedef logic [DEF_NOTE_W-1:0] note_t;
    typedef logic [DEF_VEL_W-1:0]  vel_t;

    // Per-voice lifecycle. Gate is high in HELD and SUSTAINED.
    typedef enum logic [1:0] {
        V_FREE      = 2'd0,
        V_HELD      = 2'd1,
        V_SUSTAINED = 2'd2,
        V_RELEASING = 2'd3
    } voice_state_e;

    // Event controller: accept, search for a target voice, apply the update.
    typedef enum logic [1:0] {
        A_IDLE   = 2'd0,
        A_SEARCH = 2'd1,
        A_COMMIT = 2'd2
    } alloc_state_e;

endpackage

// File: rtl/voice_allocator_voice_select.sv
// Combinational target search for a note-on: retrigger match, then free,
// then the oldest releasing, sustained or held voice (the last two steal).
module voice_select
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int NOTE_W     = DEF_NOTE_W,
    localparam int IDX_W     = $clog2(NUM_VOICES)
) (
    input  logic [NUM_VOICES-1:0][1:0]        vstate,
    input  logic [NUM_VOICES-1:0][NOTE_W-1:0] note,
    input  logic [NUM_VOICES-1:0][IDX_W-1:0]  age,
    input  logic [NOTE_W-1:0]                 ev_note,
    output logic [IDX_W-1:0]                  target,
    output logic                              found,
    output logic                              steal
);

    logic             match_found, free_found, rel_found, sus_found, held_found;
    logic [IDX_W-1:0] match_idx, free_idx, rel_idx, sus_idx, held_idx;
    logic [IDX_W-1:0] rel_age, sus_age, held_age;

    // Scan all voices once, keeping the lowest-index match/free voice and the
    // highest-age voice of each busy category, then pick by priority.
    always_comb begin
        match_found = 1'b0; match_idx = '0;
        free_found  = 1'b0; free_idx  = '0;
        rel_found   = 1'b0; rel_idx   = '0; rel_age  = '0;
        sus_found   = 1'b0; sus_idx   = '0; sus_age  = '0;
        held_found  = 1'b0; held_idx  = '0; held_age = '0;
        target      = '0;
        found       = 1'b0;
        steal       = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (vstate[i] != V_FREE && note[i] == ev_note && !match_found) begin
                match_found = 1'b1;
                match_idx   = IDX_W'(i);
            end
            if (vstate[i] == V_FREE && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (vstate[i] == V_RELEASING && (!rel_found || age[i] > rel_age)) begin
                rel_found = 1'b1;
                rel_idx   = IDX_W'(i);
                rel_age   = age[i];
            end
            if (vstate[i] == V_SUSTAINED && (!sus_found || age[i] > sus_age)) begin
                sus_found = 1'b1;
                sus_idx   = IDX_W'(i);
                sus_age   = age[i];
            end
            if (vstate[i] == V_HELD && (!held_found || age[i] > held_age)) begin
                held_found = 1'b1;
                held_idx   = IDX_W'(i);
                held_age   = age[i];
            end
        end
        if (match_found) begin
            target = match_idx; found = 1'b1;
        end else if (free_found) begin
            target = free_idx; found = 1'b1;
        end else if (rel_found) begin
            target = rel_idx; found = 1'b1;
        end else if (sus_found) begin
            target = sus_idx; found = 1'b1; steal = 1'b1;
        end else if (held_found) begin
            target = held_idx; found = 1'b1; steal = 1'b1;
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: takes note events, assigns them to voices with
// retrigger and oldest-first stealing, and tracks sustain and release.
//
// Event handshake: an event transfers on a rising clk edge where ev_valid and
// ev_ready are both 1. ev_ready is high only in IDLE, so after a transfer it
// stays low for two cycles while the event is searched and committed.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int NOTE_W     = DEF_NOTE_W,
    parameter int VEL_W      = DEF_VEL_W,
    localparam int IDX_W     = $clog2(NUM_VOICES)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ev_valid,
    output logic                              ev_ready,
    input  logic                              ev_on,
    input  logic [NOTE_W-1:0]                 ev_note,
    input  logic [VEL_W-1:0]                  ev_vel,
    input  logic                              sustain,
    input  logic [NUM_VOICES-1:0]             voice_done,
    output logic [NUM_VOICES-1:0]             gate_out,
    output logic [NUM_VOICES-1:0][NOTE_W-1:0] note_out,
    output logic [NUM_VOICES-1:0][VEL_W-1:0]  velocity_out,
    output logic [NUM_VOICES-1:0]             trig_out,
    output logic [NUM_VOICES-1:0]             busy_out,
    output logic                              steal_pulse
);

    alloc_state_e                       alloc_state;
    logic                               lat_on;
    logic [NOTE_W-1:0]                  lat_note;
    logic [VEL_W-1:0]                   lat_vel;
    logic [IDX_W-1:0]                   tgt_idx;
    logic                               tgt_found;
    logic                               tgt_steal;
    logic [NUM_VOICES-1:0][1:0]         vstate;
    logic [NUM_VOICES-1:0][IDX_W-1:0]   age;
    logic                               sustain_q;

    logic [IDX_W-1:0]                   sel_idx;
    logic                               sel_found;
    logic                               sel_steal;
    logic                               commit_on;
    logic                               commit_off;
    logic                               sus_fall;
    logic [IDX_W-1:0]                   tgt_age;

    voice_select #(
        .NUM_VOICES (NUM_VOICES),
        .NOTE_W     (NOTE_W)
    ) u_select (
        .vstate  (vstate),
        .note    (note_out),
        .age     (age),
        .ev_note (lat_note),
        .target  (sel_idx),
        .found   (sel_found),
        .steal   (sel_steal)
    );

    assign ev_ready   = (alloc_state == A_IDLE);
    assign commit_on  = (alloc_state == A_COMMIT) && lat_on && tgt_found;
    assign commit_off = (alloc_state == A_COMMIT) && !lat_on;
    assign sus_fall   = sustain_q && !sustain;
    assign tgt_age    = age[tgt_idx];

    // Controller: latch the event (velocity 0 note-on becomes note-off),
    // register the search result, then commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_state <= A_IDLE;
            lat_on      <= 1'b0;
            lat_note    <= '0;
            lat_vel     <= '0;
            tgt_idx     <= '0;
            tgt_found   <= 1'b0;
            tgt_steal   <= 1'b0;
        end else begin
            case (alloc_state)
                A_IDLE: begin
                    if (ev_valid) begin
                        lat_on      <= ev_on && (ev_vel != '0);
                        lat_note    <= ev_note;
                        lat_vel     <= ev_vel;
                        alloc_state <= A_SEARCH;
                    end
                end
                A_SEARCH: begin
                    tgt_idx     <= sel_idx;
                    tgt_found   <= sel_found;
                    tgt_steal   <= sel_steal;
                    alloc_state <= A_COMMIT;
                end
                A_COMMIT: alloc_state <= A_IDLE;
                default:  alloc_state <= A_IDLE;
            endcase
        end
    end

    // Voice bank: commit target wins over pedal release and voice_done;
    // note-off, pedal release and envelope completion act on everyone else.
    always_ff @(posedge clk) begin
        if (rst) begin
            sustain_q    <= 1'b0;
            trig_out     <= '0;
            steal_pulse  <= 1'b0;
            note_out     <= '0;
            velocity_out <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                vstate[i] <= V_FREE;
                age[i]    <= IDX_W'(i);
            end
        end else begin
            sustain_q   <= sustain;
            trig_out    <= '0;
            steal_pulse <= commit_on && tgt_steal;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (commit_on && tgt_idx == IDX_W'(i)) begin
                    vstate[i]       <= V_HELD;
                    note_out[i]     <= lat_note;
                    velocity_out[i] <= lat_vel;
                    trig_out[i]     <= 1'b1;
                    age[i]          <= '0;
                end else begin
                    if (commit_on && age[i] < tgt_age)
                        age[i] <= age[i] + 1'b1;
                    if (commit_off && vstate[i] == V_HELD && note_out[i] == lat_note)
                        vstate[i] <= sustain ? V_SUSTAINED : V_RELEASING;
                    else if (sus_fall && vstate[i] == V_SUSTAINED)
                        vstate[i] <= V_RELEASING;
                    else if (voice_done[i] && vstate[i] == V_RELEASING)
                        vstate[i] <= V_FREE;
                end
            end
        end
    end

    // Gate and busy are decoded straight from the voice state.
    always_comb begin
        gate_out = '0;
        busy_out = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            gate_out[i] = (vstate[i] == V_HELD) || (vstate[i] == V_SUSTAINED);
            busy_out[i] = (vstate[i] != V_FREE);
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with hand-computed expectations.
module tb_voice_allocator;

    localparam int N  = 8;
    localparam int NW = 7;
    localparam int VW = 3;

    logic                  clk;
    logic                  rst;
    logic                  ev_valid;
    logic                  ev_ready;
    logic                  ev_on;
    logic [NW-1:0]         ev_note;
    logic [VW-1:0]         ev_vel;
    logic                  sustain;
    logic [N-1:0]          voice_done;
    logic [N-1:0]          gate_out;
    logic [N-1:0][NW-1:0]  note_out;
    logic [N-1:0][VW-1:0]  velocity_out;
    logic [N-1:0]          trig_out;
    logic [N-1:0]          busy_out;
    logic                  steal_pulse;

    int n_checks = 0;
    int n_errors = 0;
    logic [NW-1:0] exp_q[$];

    voice_allocator #(.NUM_VOICES(N), .NOTE_W(NW), .VEL_W(VW)) dut (
        .clk          (clk),
        .rst          (rst),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_on        (ev_on),
        .ev_note      (ev_note),
        .ev_vel       (ev_vel),
        .sustain      (sustain),
        .voice_done   (voice_done),
        .gate_out     (gate_out),
        .note_out     (note_out),
        .velocity_out (velocity_out),
        .trig_out     (trig_out),
        .busy_out     (busy_out),
        .steal_pulse  (steal_pulse)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        ev_valid   = 1'b0;
        ev_on      = 1'b0;
        ev_note    = '0;
        ev_vel     = '0;
        sustain    = 1'b0;
        voice_done = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Returns just after the handshake edge (controller now in SEARCH).
    task automatic send_event(input logic on, input logic [NW-1:0] note, input logic [VW-1:0] vel);
        int guard = 0;
        ev_valid = 1'b1;
        ev_on    = on;
        ev_note  = note;
        ev_vel   = vel;
        while (!ev_ready && guard < 20) begin
            @(posedge clk);
            #1 guard++;
        end
        check_val("ready_timeout", (guard < 20), 1'b1);
        @(posedge clk);
        #1 ev_valid = 1'b0;
    endtask

    // Full event: returns in the first cycle where the commit is visible.
    task automatic play(input logic on, input logic [NW-1:0] note, input logic [VW-1:0] vel);
        send_event(on, note, vel);
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int accepted;
        int bad;
        logic rdy;

        // Reset state and first note-on latency
        do_reset();
        check_val("rst_ready", ev_ready, 1'b1);
        check_val("rst_gate", gate_out, 8'h00);
        check_val("rst_busy", busy_out, 8'h00);
        check_val("rst_trig", trig_out, 8'h00);
        check_val("rst_notes", note_out, 56'h0);
        check_val("rst_steal", steal_pulse, 1'b0);

        send_event(1'b1, 7'd60, 3'd5);
        check_val("lat_c1_gate", gate_out, 8'h00);
        check_val("lat_c1_ready", ev_ready, 1'b0);
        tick();
        check_val("lat_c2_gate", gate_out, 8'h00);
        check_val("lat_c2_ready", ev_ready, 1'b0);
        tick();
        check_val("on60_gate", gate_out, 8'h01);
        check_val("on60_note", note_out[0], 7'd60);
        check_val("on60_vel", velocity_out[0], 3'd5);
        check_val("on60_trig", trig_out, 8'h01);
        check_val("on60_ready", ev_ready, 1'b1);
        tick();
        check_val("on60_trig_end", trig_out, 8'h00);
        check_val("on60_gate_hold", gate_out, 8'h01);

        // Fill all voices, then steal the oldest
        do_reset();
        for (int k = 0; k < 8; k++) play(1'b1, 7'(60 + 2 * k), 3'd4);
        check_val("fill_busy", busy_out, 8'hff);
        check_val("fill_note7", note_out[7], 7'd74);
        check_val("fill_steal", steal_pulse, 1'b0);
        play(1'b1, 7'd76, 3'd6);
        check_val("steal_note0", note_out[0], 7'd76);
        check_val("steal_vel0", velocity_out[0], 3'd6);
        check_val("steal_pulse", steal_pulse, 1'b1);
        check_val("steal_trig", trig_out, 8'h01);
        check_val("steal_note1", note_out[1], 7'd62);
        check_val("steal_note7", note_out[7], 7'd74);
        check_val("steal_gate", gate_out, 8'hff);
        tick();
        check_val("steal_pulse_end", steal_pulse, 1'b0);
        // Next steal must go to voice 1, now the oldest
        play(1'b1, 7'd78, 3'd6);
        check_val("steal2_note1", note_out[1], 7'd78);
        check_val("steal2_note0", note_out[0], 7'd76);
        check_val("steal2_trig", trig_out, 8'h02);

        // Same-note retrigger
        do_reset();
        play(1'b1, 7'd60, 3'd5);
        tick();
        play(1'b1, 7'd60, 3'd7);
        check_val("retrig_busy", busy_out, 8'h01);
        check_val("retrig_trig", trig_out, 8'h01);
        check_val("retrig_steal", steal_pulse, 1'b0);
        check_val("retrig_vel", velocity_out[0], 3'd7);

        // Velocity-0 note-on acts as note-off
        play(1'b1, 7'd60, 3'd0);
        check_val("vel0_gate", gate_out, 8'h00);
        check_val("vel0_busy", busy_out, 8'h01);
        check_val("vel0_trig", trig_out, 8'h00);

        // Sustain pedal and release completion
        do_reset();
        sustain = 1'b1;
        play(1'b1, 7'd60, 3'd5);
        play(1'b0, 7'd60, 3'd0);
        check_val("sus_gate", gate_out, 8'h01);
        check_val("sus_busy", busy_out, 8'h01);
        play(1'b0, 7'd61, 3'd0);
        check_val("off_nomatch_gate", gate_out, 8'h01);
        sustain = 1'b0;
        tick();
        check_val("sus_drop_gate", gate_out, 8'h00);
        check_val("sus_drop_busy", busy_out, 8'h01);
        voice_done = 8'h01;
        tick();
        voice_done = 8'h00;
        check_val("done_busy", busy_out, 8'h00);
        check_val("done_note_hold", note_out[0], 7'd60);

        // Releasing voice preferred over held; voice_done in COMMIT loses
        do_reset();
        for (int k = 0; k < 8; k++) play(1'b1, 7'(60 + 2 * k), 3'd4);
        play(1'b0, 7'd62, 3'd0);
        check_val("rel_gate", gate_out, 8'hfd);
        send_event(1'b1, 7'd80, 3'd3);
        tick();
        voice_done = 8'h02;
        tick();
        voice_done = 8'h00;
        check_val("rel_take_note", note_out[1], 7'd80);
        check_val("rel_take_steal", steal_pulse, 1'b0);
        check_val("rel_take_trig", trig_out, 8'h02);
        check_val("rel_take_gate", gate_out, 8'hff);
        tick();
        check_val("rel_take_hold", gate_out, 8'hff);
        check_val("rel_take_busy", busy_out, 8'hff);

        // Back-to-back events with ev_valid held high
        do_reset();
        accepted = 0;
        bad = 0;
        ev_valid = 1'b1;
        ev_on    = 1'b1;
        ev_vel   = 3'd3;
        ev_note  = 7'd40;
        for (int c = 0; c < 30 && accepted < 5; c++) begin
            rdy = ev_ready;
            if (rdy !== ((c % 3) == 0)) bad++;
            if (rdy) begin
                exp_q.push_back(ev_note);
                accepted++;
            end
            @(posedge clk);
            #1;
            if (rdy) ev_note = 7'(40 + accepted);
        end
        ev_valid = 1'b0;
        tick();
        tick();
        tick();
        check_val("b2b_accepted", accepted, 5);
        check_val("b2b_ready_pattern_errs", bad, 0);
        check_val("b2b_busy", busy_out, 8'h1f);
        for (int v = 0; v < 5; v++) begin
            logic [NW-1:0] e;
            e = exp_q.pop_front();
            check_val($sformatf("b2b_note%0d", v), note_out[v], e);
        end

        // Reset while the event is in SEARCH drops it
        send_event(1'b1, 7'd50, 3'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        check_val("rst_search_busy", busy_out, 8'h00);
        check_val("rst_search_gate", gate_out, 8'h00);
        check_val("rst_search_ready", ev_ready, 1'b1);
        check_val("rst_search_note0", note_out[0], 7'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
Schedules the synth's polyphonic voice resource. Accepts parsed note-on/note-off events from the MIDI front end over a valid/ready handshake. Assigns each note to one of NUM_VOICES oscillator/envelope voices, with same-note retrigger and oldest-first voice stealing. Tracks sustain pedal and envelope-release completion so a voice is reused only when it is truly free.

Parameters:
NUM_VOICES, 8, number of voices (power of 2, 2..16)
NOTE_W, 7, MIDI note number width
VEL_W, 3, velocity width delivered to voices
IDX_W, $clog2(NUM_VOICES), voice index / age rank width (localparam)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ev_valid  in  1  event present
ev_ready  out  1  allocator can accept event
ev_on  in  1  1 = note-on, 0 = note-off
ev_note  in  NOTE_W  note number
ev_vel  in  VEL_W  velocity; note-on with ev_vel==0 is treated as note-off
sustain  in  1  sustain pedal level (already synchronous)
voice_done  in  NUM_VOICES  per-voice envelope reached zero after release
gate_out  out  NUM_VOICES  envelope gate per voice
note_out  out  NUM_VOICES x NOTE_W  note per voice
velocity_out  out  NUM_VOICES x VEL_W  velocity per voice
trig_out  out  NUM_VOICES  1-cycle attack (re)trigger pulse
busy_out  out  NUM_VOICES  voice not FREE
steal_pulse  out  1  1-cycle pulse when a HELD or SUSTAINED voice was stolen

Behaviour:
- Reset: every voice FREE. gate_out, trig_out, busy_out, note_out, velocity_out, steal_pulse = 0. Age rank of voice i = i. Controller in IDLE with ev_ready = 1.
- Per-voice state: FREE, HELD (gate=1), SUSTAINED (key up, pedal down, gate=1), RELEASING (gate=0, awaiting voice_done).
- Controller FSM:
  - IDLE: ev_ready=1. On ev_valid, latch event; go SEARCH.
  - SEARCH: ev_ready=0. Compute target voice plus steal flag from latched event; register them; go COMMIT.
  - COMMIT: ev_ready=0. Apply update; go IDLE.
- Latency: outputs change in the cycle after COMMIT, i.e. 3 cycles after handshake. Max throughput is 1 event per 3 cycles.
- Note-on target priority:
  1. any non-FREE voice with matching note (lowest index) — retrigger;
  2. lowest-index FREE voice;
  3. RELEASING voice with highest age;
  4. SUSTAINED voice with highest age;
  5. HELD voice with highest age.
- steal_pulse is asserted only for cases 4 and 5.
- Note-on commit: voice becomes HELD, gate=1. note/velocity are loaded and trig pulses for that voice. Target age becomes 0; every voice with age < target's old age increments. Ages stay a permutation of 0..N-1.
- Note-off commit: every HELD voice with matching note goes to SUSTAINED if sustain=1, else RELEASING. No match is a no-op with no error. Ages are unchanged.
- Sustain falling edge (registered previous value): all SUSTAINED voices go to RELEASING. In the same cycle as a COMMIT, this applies to all voices except the commit target.
- voice_done[i]: RELEASING goes to FREE, clearing busy; note/velocity are held. Ignored in other states. A COMMIT to the same voice in the same cycle wins.
- Reset mid-operation: immediate return to reset state; the latched event is dropped.
- ev_* must be stable only during the handshake cycle.

Decomposition:
- Package synth_pkg holds:
  - voice_state_e enum (FREE/HELD/SUSTAINED/RELEASING);
  - alloc_state_e (IDLE/SEARCH/COMMIT);
  - note_t and vel_t typedefs;
  - NUM_VOICES default constant, shared with the voice bank.
- One sub-module, voice_select: purely combinational priority/oldest search producing target index, found flag and steal flag. It is registered in SEARCH.

Test Plan:
- Reset, then note-on 60 vel 5 → voice 0 gate=1, note_out[0]=60, vel 5, trig_out[0] pulses 1 cycle, 3 cycles after handshake.
- Note-on 60,62,64,…,74 (8 notes), then note-on 76 → voice 0 (oldest) stolen, note_out[0]=76, steal_pulse=1, others unchanged.
- Note-on 60 twice → second reuses voice 0 with trig pulse; busy_out=0000_0001; no steal.
- sustain=1, on 60, off 60 → voice 0 SUSTAINED, gate=1. Drop sustain → gate=0. voice_done[0] → busy_out[0]=0.
- Voice 1 RELEASING, voice 0 HELD, all others HELD → next note-on takes voice 1 with steal_pulse=0. voice_done[1] asserted in the COMMIT cycle → voice 1 ends HELD.
- ev_valid held high for 5 back-to-back events → ev_ready low 2 of every 3 cycles. All 5 are accepted exactly once; rst asserted in SEARCH drops the pending event.
